// File: rtl/dmem_mmio_if.sv
// Data-bus and console-drain signals between the MIPS core side and dmem_mmio.
// master drives requests and tx_ready; slave returns read data and the TX stream.
interface dmem_mmio_if;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        misalign_err;

    modport master (
        output memwrite, aluout, writedata, tx_ready,
        input  readdata, tx_data, tx_valid, misalign_err
    );

    modport slave (
        input  memwrite, aluout, writedata, tx_ready,
        output readdata, tx_data, tx_valid, misalign_err
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory plus MMIO page (timer, console TX FIFO, status, error flag).
// Optional DMEM_MISALIGN_CHECK_EN suppresses misaligned writes and flags them.
module dmem_mmio #(
    parameter int MEM_WORDS  = 64,
    parameter int ADDR_BITS  = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_PTR   = 3,
    parameter int TIMER_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus
);
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [31:0]          ram [MEM_WORDS];
    logic [ADDR_BITS-1:0] idx;
    logic                 is_mmio;
    logic [15:0]          off;
    logic                 sel_timer, sel_tx, sel_stat, sel_err;
    logic                 wr_ok;

    logic [31:0]   count;
    logic [PW-1:0] pre;
    logic          tick;

    logic [7:0]          fifo [FIFO_DEPTH];
    logic [FIFO_PTR-1:0] wptr, rptr;
    logic [FIFO_PTR:0]   cnt;
    logic                empty, full, pop, push, do_push, ovf;
    logic                err;
    logic [31:0]         mmio_rd;

    assign idx       = bus.aluout[ADDR_BITS+1:2];
    assign is_mmio   = bus.aluout[31:16] == 16'hFFFF;
    assign off       = bus.aluout[15:0];
    assign sel_timer = is_mmio && off == 16'h0000;
    assign sel_tx    = is_mmio && off == 16'h0004;
    assign sel_stat  = is_mmio && off == 16'h0008;
    assign sel_err   = is_mmio && off == 16'h000C;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misal;
    assign misal = bus.memwrite && bus.aluout[1:0] != 2'b00;
    assign wr_ok = bus.memwrite && !misal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (misal)
            err <= 1'b1;
        else if (wr_ok && sel_err)
            err <= 1'b0;
    end
`else
    assign wr_ok = bus.memwrite;
    assign err   = 1'b0;
`endif

    assign bus.misalign_err = err;

    always_ff @(posedge clk) begin
        if (wr_ok && !is_mmio)
            ram[idx] <= bus.writedata;
    end

    assign tick = pre == PW'(TIMER_DIV - 1);

    // A software load restarts the prescaler so the next tick is a full period away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'h0;
            pre   <= '0;
        end else if (wr_ok && sel_timer) begin
            count <= bus.writedata;
            pre   <= '0;
        end else if (tick) begin
            count <= count + 32'h1;
            pre   <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign empty   = cnt == '0;
    assign full    = cnt == (FIFO_PTR+1)'(FIFO_DEPTH);
    assign pop     = !empty && bus.tx_ready;
    assign push    = wr_ok && sel_tx;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({do_push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && full && !pop)
                ovf <= 1'b1;
            else if (wr_ok && sel_stat)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            fifo[wptr] <= bus.writedata[7:0];
    end

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo[rptr];

    always_comb begin
        mmio_rd = 32'h0;
        unique case (1'b1)
            sel_timer: mmio_rd = count;
            sel_stat:  mmio_rd = {ovf, 20'h0, 9'(cnt), full, empty};
            sel_err:   mmio_rd = {31'h0, err};
            default:   mmio_rd = 32'h0;
        endcase
    end

    assign bus.readdata = is_mmio ? mmio_rd : ram[idx];
endmodule
